load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator-side controller for the byte-addressed unified memory in the multicycle RISC-V datapath.
- Accepts one load or store request per transaction from the multicycle control and drives the memory's address, writeData, memRead and memWrite pins.
- The memory only supports full 32-bit accesses: a combinational read and a synchronous 4-byte write. This block therefore implements:
  - sb and sh as read-modify-write;
  - lb, lh, lbu and lhu as read-then-extract with sign or zero extension.
- It also flags misaligned, out-of-range and illegal accesses.

Parameters:
MEM_BYTES, 256, size of memory byte array; access faults if addr+3 > MEM_BYTES-1
CHECK_ALIGN, 1, 1 = fault on misaligned (lh/lhu/sh odd addr; lw/sw addr[1:0]!=0); 0 = no alignment check

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; transfer = req_valid && req_ready at posedge
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2); low byte/half used for sb/sh
rsp_valid  out  1  one-cycle pulse, response valid
rsp_rdata  out  32  extended load data; 0 for stores and faults
rsp_fault  out  1  access fault, qualified by rsp_valid
mem_address  out  32  to memory address
mem_writeData  out  32  to memory writeData
mem_memRead  out  1  to memory memRead
mem_memWrite  out  1  to memory memWrite
mem_memData  in  32  from memory memData (combinational, same cycle)

Behaviour:
- Reset:
  - state=IDLE; all latched regs 0; rsp_valid=0, rsp_rdata=0, rsp_fault=0.
  - mem_memRead=0, mem_memWrite=0, mem_address=0, mem_writeData=0.
  - req_ready=0 while reset is high.
  - reset mid-transaction aborts it: no memWrite is asserted in any cycle where reset=1, and no response is issued.
- Handshake:
  - On transfer, latch write, funct3, addr and wdata.
  - req_* are ignored outside IDLE.
- Fault check (evaluated at accept):
  - illegal funct3: load 011/11x; store anything other than 000/001/010;
  - out-of-range: addr > MEM_BYTES-4, compared as unsigned 32-bit, no wrap;
  - misaligned, when CHECK_ALIGN=1.
  - On any fault, go to RESP with rsp_fault=1. The memory is never accessed.
- States:
  - IDLE: req_ready=1.
    - On accept: fault -> RESP; load -> LOAD; sw -> WRITE (merged = wdata); sb/sh -> RMW_RD.
  - LOAD: mem_memRead=1, mem_address=addr.
    - Capture extended mem_memData at posedge, then -> RESP.
    - Extraction uses offset 0 of the returned word, because memory returns bytes addr..addr+3:
      - lb: sign-extend [7:0]; lbu: zero-extend [7:0];
      - lh: sign-extend [15:0]; lhu: zero-extend [15:0];
      - lw: full word.
  - RMW_RD: mem_memRead=1, mem_address=addr.
    - merged = sb: {memData[31:8], wdata[7:0]}; sh: {memData[31:16], wdata[15:0]}; then -> WRITE.
  - WRITE: mem_memWrite=1, mem_address=addr, mem_writeData=merged; -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle, with rdata/fault held; -> IDLE.
- Outside the listed cycles, mem_memRead and mem_memWrite are 0. mem_memRead and mem_memWrite are never both 1.
- Latency, counted from the accept edge T:
  - load: rsp_valid in cycle T+2;
  - sw: memWrite in T+1, rsp in T+2;
  - sb/sh: read in T+1, write in T+2, rsp in T+3;
  - fault: rsp in T+1.
- Throughput: the next request can be accepted in the cycle after RESP.
- rsp_rdata and rsp_fault hold their last values until the next RESP. The bench only checks them when rsp_valid=1.

Test Plan:
- Preload word 0x8081_7F01 at addr 0x80. Issue lb 0x80 -> rsp_rdata=0x0000_0001; lb 0x82 -> 0xFFFF_FF81; lbu 0x83 -> 0x0000_0080; lh 0x82 -> 0xFFFF_8081; lw 0x80 -> 0x8081_7F01. Each response arrives 2 cycles after accept.
- sw 0xDEAD_BEEF to 0x84, then sb 0x55 to 0x85, then lw 0x84. Required:
  - the sb read/write sequence is visible on the memory pins;
  - the lw returns 0xDEAD_55EF with fault=0;
  - memWrite pulses for 1 cycle per store.
- sh 0x1234 to 0x86 after the above, then lw 0x84 -> 0x1234_55EF. Response arrives 3 cycles after accept.
- Fault cases:
  - lw 0x81 with CHECK_ALIGN=1;
  - lw 0xFD;
  - store with funct3=100.
  - Each must give rsp_fault=1, rsp_rdata=0 in T+1, and no memRead/memWrite.
  - lw 0x81 with CHECK_ALIGN=0 returns bytes 0x81..0x84.
- Issue sb, then assert reset in the RMW_RD cycle. Required:
  - memWrite is never asserted and no rsp_valid is issued;
  - after reset, req_ready=1 and the memory word is unchanged.
- Hold req_valid high with back-to-back requests. Required:
  - req_ready=0 outside IDLE;
  - exactly one accept per transaction;
  - a changing req_addr mid-transaction does not alter mem_address.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only unified memory: sub-word stores become
// read-modify-write, sub-word loads are extracted and extended from offset 0.
module load_store_unit #(
  parameter int MEM_BYTES   = 256,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_memData,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and out of reset, and rsp_valid pulses one cycle.
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  state_t      state;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] merged_q;
  logic        illegal, misaligned, out_of_range, fault;
  logic [31:0] load_data;

  always_comb begin
    illegal      = 1'b0;
    misaligned   = 1'b0;
    out_of_range = req_addr > LAST_ADDR;
    if (req_write)
      illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
    else
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = req_addr[1:0] != 2'b00;
      default: misaligned = 1'b0;
    endcase
    fault = illegal || out_of_range || (CHECK_ALIGN && misaligned);
  end

  // The memory returns bytes addr..addr+3, so sub-word data sits at offset 0.
  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{24{mem_memData[7]}}, mem_memData[7:0]};
      3'b001:  load_data = {{16{mem_memData[15]}}, mem_memData[15:0]};
      3'b100:  load_data = {24'd0, mem_memData[7:0]};
      3'b101:  load_data = {16'd0, mem_memData[15:0]};
      default: load_data = mem_memData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      funct3_q  <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 16'd0;
      merged_q  <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata[15:0];
            if (fault) begin
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_rdata <= 32'd0;
              state     <= RESP;
            end else if (!req_write) begin
              state <= LOAD;
            end else if (req_funct3 == 3'b010) begin
              merged_q <= req_wdata;
              state    <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rsp_valid <= 1'b1;
          rsp_fault <= 1'b0;
          rsp_rdata <= load_data;
          state     <= RESP;
        end
        RMW_RD: begin
          merged_q <= funct3_q[0] ? {mem_memData[31:16], wdata_q}
                                  : {mem_memData[31:8], wdata_q[7:0]};
          state    <= WRITE;
        end
        WRITE: begin
          rsp_valid <= 1'b1;
          rsp_fault <= 1'b0;
          rsp_rdata <= 32'd0;
          state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by reset so an aborted transaction can never write.
  assign req_ready     = (state == IDLE) && !reset;
  assign mem_memRead   = (state == LOAD || state == RMW_RD) && !reset;
  assign mem_memWrite  = (state == WRITE) && !reset;
  assign mem_address   = (state == LOAD || state == RMW_RD || state == WRITE) ? addr_q : 32'd0;
  assign mem_writeData = (state == WRITE) ? merged_q : 32'd0;
  assign dbg_state     = state;

endmodule
